// File: rtl/sort_sequencer.sv
// -----------------------------------------------------------------------------
// sort_sequencer
//   Bubble-sort controller for an N-entry signed array held in an external
//   single-port synchronous RAM. Each compare step reads an adjacent pair,
//   compares the two values as signed numbers and, if they are out of order,
//   writes them back swapped. Each pass shrinks the upper bound by one. The
//   sort ends early after a pass with no swaps. Pass and swap counts stay
//   visible until the next start.
//
// Ports
//   clock       in   1           single clock, posedge
//   reset_n     in   1           asynchronous active-low reset
//   start       in   1           begin a sort (sampled only while idle)
//   busy        out  1           high from the cycle after start through DONE
//   done        out  1           one-cycle completion pulse
//   mem_addr    out  ADDR_W      RAM address
//   mem_rd      out  1           read strobe; mem_rdata valid next cycle
//   mem_rdata   in   DATA_W      RAM read data
//   mem_we      out  1           write strobe
//   mem_wdata   out  DATA_W      RAM write data (held while mem_we is low)
//   pass_count  out  ADDR_W+1    passes completed in the last/current sort
//   swap_count  out  2*ADDR_W+1  swaps performed in the last/current sort
// -----------------------------------------------------------------------------
module sort_sequencer #(
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [ADDR_W:0]     pass_count,
  output logic [2*ADDR_W:0]   swap_count
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD_A = 3'd1;
  localparam logic [2:0] S_RD_B = 3'd2;
  localparam logic [2:0] S_CMP  = 3'd3;
  localparam logic [2:0] S_WR_A = 3'd4;
  localparam logic [2:0] S_WR_B = 3'd5;
  localparam logic [2:0] S_ADV  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  localparam logic [ADDR_W-1:0] LAST_INIT = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  logic [2:0]        state, state_n;
  logic [ADDR_W-1:0] i, i_n;
  logic [ADDR_W-1:0] last, last_n;
  logic [ADDR_W-1:0] i_inc;
  logic [DATA_W-1:0] a;
  logic              swapped;
  logic              do_swap;
  logic              more_pairs;
  logic              end_of_pass;

  // i < last <= N-1 <= 2**ADDR_W-1, so i+1 never wraps.
  assign i_inc       = i + ONE;
  assign more_pairs  = i_inc < last;
  assign end_of_pass = (state == S_ADV) && !more_pairs;
  // In CMP, mem_rdata carries element i+1 (the b operand).
  assign do_swap     = $signed(a) > $signed(mem_rdata);

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    i_n     = i;
    last_n  = last;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RD_A;
          i_n     = '0;
          last_n  = LAST_INIT;
        end
      end
      S_RD_A: state_n = S_RD_B;
      S_RD_B: state_n = S_CMP;
      S_CMP:  state_n = do_swap ? S_WR_A : S_ADV;
      S_WR_A: state_n = S_WR_B;
      S_WR_B: state_n = S_ADV;
      S_ADV: begin
        if (more_pairs) begin
          i_n     = i_inc;
          state_n = S_RD_A;
        end else if (!swapped || last == ONE) begin
          state_n = S_DONE;
        end else begin
          last_n  = last - ONE;
          i_n     = '0;
          state_n = S_RD_A;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so that the strobes, address
  // and write data are valid during the state they belong to.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      i          <= '0;
      last       <= '0;
      a          <= '0;
      swapped    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_rd     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      pass_count <= '0;
      swap_count <= '0;
    end else begin
      state  <= state_n;
      i      <= i_n;
      last   <= last_n;
      busy   <= (state_n != S_IDLE);
      done   <= (state_n == S_DONE);
      mem_rd <= (state_n == S_RD_A) || (state_n == S_RD_B);
      mem_we <= (state_n == S_WR_A) || (state_n == S_WR_B);

      case (state_n)
        S_RD_A, S_WR_A: mem_addr <= i_n;
        S_RD_B, S_WR_B: mem_addr <= i_n + ONE;
        default: ;
      endcase

      // The b operand is taken straight from mem_rdata on the CMP->WR_A
      // edge, so mem_wdata itself holds b; no separate b register is kept.
      if (state_n == S_WR_A) mem_wdata <= mem_rdata;
      if (state_n == S_WR_B) mem_wdata <= a;

      case (state)
        S_IDLE: begin
          if (start) begin
            swapped    <= 1'b0;
            pass_count <= '0;
            swap_count <= '0;
          end
        end
        S_RD_B: a <= mem_rdata;
        S_WR_B: begin
          swapped    <= 1'b1;
          swap_count <= swap_count + (2*ADDR_W+1)'(1);
        end
        S_ADV: begin
          if (end_of_pass) begin
            pass_count <= pass_count + (ADDR_W+1)'(1);
            swapped    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sort_sequencer
//   Self-checking bench for sort_sequencer. A behavioural RAM sits on the
//   memory port; a plain array bubble sort with early exit predicts the final
//   array, pass/swap counts, write count and cycles to done.
// -----------------------------------------------------------------------------
module tb_sort_sequencer;

  localparam int N  = 8;
  localparam int DW = 32;
  localparam int AW = 3;

  logic            clock   = 1'b0;
  logic            reset_n = 1'b0;
  logic            start   = 1'b0;
  logic            busy, done, mem_rd, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata;
  logic [DW-1:0]   mem_wdata;
  logic [AW:0]     pass_count;
  logic [2*AW:0]   swap_count;

  logic signed [DW-1:0] ram      [N];
  logic signed [DW-1:0] load_buf [N];
  logic                 load_req = 1'b0;

  int checks    = 0;
  int errors    = 0;
  int writes    = 0;
  int proto_err = 0;

  always #5 clock = ~clock;

  sort_sequencer #(.N(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .pass_count (pass_count),
    .swap_count (swap_count)
  );

  // Single-port synchronous RAM plus protocol monitor.
  always @(posedge clock) begin
    if (load_req) begin
      ram <= load_buf;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_rd) mem_rdata <= ram[mem_addr];
    end
    if (mem_we) writes++;
    if (mem_rd && mem_we) proto_err++;
    if (int'(mem_addr) > N - 1) proto_err++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: bubble sort with shrinking bound and early exit.
  task automatic model(input logic signed [DW-1:0] src [N],
                       output logic signed [DW-1:0] dst [N],
                       output int passes, output int swaps, output int compares);
    logic signed [DW-1:0] t;
    bit any;
    dst = src;
    passes = 0; swaps = 0; compares = 0;
    for (int lim = N - 1; lim >= 1; lim--) begin
      any = 1'b0;
      for (int k = 0; k < lim; k++) begin
        compares++;
        if (dst[k] > dst[k+1]) begin
          t = dst[k]; dst[k] = dst[k+1]; dst[k+1] = t;
          swaps++;
          any = 1'b1;
        end
      end
      passes++;
      if (!any) break;
    end
  endtask

  task automatic load(input logic signed [DW-1:0] v [N]);
    load_buf = v;
    load_req = 1'b1;
    @(posedge clock); #1;
    load_req = 1'b0;
  endtask

  // Runs one sort of the current RAM contents. With poke set, start is also
  // pulsed mid-sort and in the DONE cycle; both must be ignored.
  task automatic run_sort(input string tag, input bit poke);
    logic signed [DW-1:0] src [N];
    logic signed [DW-1:0] exp [N];
    int p, s, c, cyc, w0;
    src = ram;
    model(src, exp, p, s, c);
    w0 = writes;
    check($sformatf("%s idle", tag), {busy, done}, 2'b00);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 1;
    check($sformatf("%s busy_on", tag), busy, 1'b1);
    while (done !== 1'b1 && cyc < 1000) begin
      start = poke && (cyc == 9);
      @(posedge clock); #1;
      cyc++;
    end
    start = 1'b0;
    check($sformatf("%s done", tag), done, 1'b1);
    check($sformatf("%s cycles", tag), cyc, 4 * c + 2 * s + 1);
    check($sformatf("%s busy_in_done", tag), busy, 1'b1);
    check($sformatf("%s pass", tag), pass_count, p);
    check($sformatf("%s swap", tag), swap_count, s);
    start = poke;
    @(posedge clock); #1;
    start = 1'b0;
    check($sformatf("%s after_done", tag), {busy, done}, 2'b00);
    @(posedge clock); #1;
    check($sformatf("%s stays_idle", tag), {busy, done}, 2'b00);
    check($sformatf("%s hold_pass", tag), pass_count, p);
    check($sformatf("%s hold_swap", tag), swap_count, s);
    for (int k = 0; k < N; k++)
      check($sformatf("%s ram[%0d]", tag, k), ram[k], exp[k]);
    check($sformatf("%s writes", tag), writes - w0, 2 * s);
  endtask

  initial begin
    logic signed [DW-1:0] v [N];
    logic [AW-1:0]        wb_addr;
    logic signed [DW-1:0] wb_old;
    int                   t;

    #2;
    check("reset_outputs",
          {busy, done, mem_rd, mem_we, mem_addr, mem_wdata, pass_count, swap_count}, '0);
    #10 reset_n = 1'b1;

    // 1: already sorted
    v = '{0, 10, 20, 30, 40, 50, 60, 70};
    load(v);
    run_sort("t1_sorted", 1'b0);

    // 2: three large values must travel past four small ones
    v = '{0, 1010, 2020, 3030, 40, 50, 60, 70};
    load(v);
    run_sort("t2_mixed", 1'b0);

    // 3: reverse order, worst case
    v = '{70, 60, 50, 40, 30, 20, 10, 0};
    load(v);
    run_sort("t3_reverse", 1'b0);

    // 4: signed values with duplicates
    v = '{5, -1, 5, -32768, 0, -1, 7, 0};
    load(v);
    run_sort("t4_signed", 1'b0);

    // 5: start pulses during busy and in DONE are ignored
    v = '{0, 1010, 2020, 3030, 40, 50, 60, 70};
    load(v);
    run_sort("t5_poke", 1'b1);

    // randomized arrays: narrow range (many duplicates) and full range
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++)
        v[k] = (r < 2) ? DW'($urandom_range(0, 6)) - DW'(3) : DW'($urandom);
      load(v);
      run_sort($sformatf("rand%0d", r), 1'b0);
    end

    // 6: reset during WR_B, then re-sort the partially sorted RAM
    v = '{70, 60, 50, 40, 30, 20, 10, 0};
    load(v);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    t = 0;
    while (mem_we !== 1'b1 && t < 500) begin
      @(posedge clock); #1;
      t++;
    end
    check("t6 reach_wr_a", mem_we, 1'b1);
    @(posedge clock); #1;
    check("t6 in_wr_b", {mem_we, mem_rd}, 2'b10);
    wb_addr = mem_addr;
    wb_old  = ram[mem_addr];
    #2 reset_n = 1'b0;
    #1;
    check("t6 async_reset",
          {busy, done, mem_rd, mem_we, mem_addr, mem_wdata, pass_count, swap_count}, '0);
    repeat (2) @(posedge clock);
    #1;
    check("t6 no_write_after_reset", ram[wb_addr], wb_old);
    reset_n = 1'b1;
    @(posedge clock); #1;
    run_sort("t6_resort", 1'b0);

    check("protocol", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
